// File: rtl/prefetch_queue.sv
// prefetch_queue: sequential instruction-byte prefetcher feeding the decoder through a small FIFO.
// Optional macro PFQ_BYPASS_EN presents an arriving byte combinationally when the FIFO is empty.
module prefetch_queue #(
    parameter int DEPTH   = 6,
    parameter int ADDR_W  = 20,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              locked,
    input  logic              bus_hold,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic [ADDR_W-1:0] address,
    output logic              fetch,
    input  logic [7:0]        din,
    output logic [7:0]        q_data,
    output logic [ADDR_W-1:0] q_ip,
    output logic              q_valid,
    input  logic              q_take,
    output logic [3:0]        q_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0]  fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W-1:0]  address_q, address_d;
    logic [ADDR_W-1:0]  ip_q, ip_d;
    logic               fetch_q, fetch_d;
    logic [LATENCY-1:0] tag_q, tag_d;
    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [3:0]         count_q, count_d;
    logic [7:0]         head_q, head_d;
    logic               valid_q, valid_d;

    logic       tag_end;
    logic       bypass_hit;
    logic       take_ok;
    logic       push;
    logic       pop;
    logic       issue;
    logic [4:0] inflight;
    logic [4:0] credit_used;
    logic [4:0] credit_limit;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign tag_end = tag_q[LATENCY-1];

`ifdef PFQ_BYPASS_EN
    assign bypass_hit = tag_end && !flush && (count_q == 4'd0);
    assign q_valid    = valid_q || bypass_hit;
    assign q_data     = bypass_hit ? din : head_q;
`else
    assign bypass_hit = 1'b0;
    assign q_valid    = valid_q;
    assign q_data     = head_q;
`endif

    assign take_ok = q_take && q_valid;
    // A bypassed byte that is taken in its arrival cycle never touches the FIFO.
    assign push    = tag_end && !(bypass_hit && q_take);
    assign pop     = q_take && valid_q;

    assign inflight     = 5'($countones(tag_q));
    assign credit_used  = {1'b0, count_q} + inflight;
    assign credit_limit = 5'(DEPTH) + {4'd0, take_ok};
    assign issue        = locked && !bus_hold && !flush && (credit_used < credit_limit);

    always_comb begin
        fetch_ptr_d = fetch_ptr_q;
        address_d   = address_q;
        fetch_d     = 1'b0;
        ip_d        = ip_q;
        tag_d       = '0;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        head_d      = head_q;
        valid_d     = valid_q;

        if (flush) begin
            fetch_ptr_d = flush_addr;
            ip_d        = flush_addr;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = 4'd0;
            head_d      = 8'h00;
            valid_d     = 1'b0;
        end else begin
            tag_d = LATENCY'({tag_q, issue});
            if (issue) begin
                fetch_d     = 1'b1;
                address_d   = fetch_ptr_q;
                fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
            end
            if (take_ok) begin
                ip_d = ip_q + ADDR_W'(1);
            end
            if (push) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            count_d = count_q + 4'(push) - 4'(pop);
            valid_d = (count_d != 4'd0);
            // Head register holds the next byte so q_data never depends on a RAM read mux path.
            if (count_d == 4'd0) begin
                head_d = 8'h00;
            end else if ((count_q - 4'(pop)) != 4'd0) begin
                head_d = mem_q[rd_ptr_d];
            end else begin
                head_d = din;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_ptr_q <= '0;
            address_q   <= '0;
            fetch_q     <= 1'b0;
            ip_q        <= '0;
            tag_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= 4'd0;
            head_q      <= 8'h00;
            valid_q     <= 1'b0;
        end else begin
            fetch_ptr_q <= fetch_ptr_d;
            address_q   <= address_d;
            fetch_q     <= fetch_d;
            ip_q        <= ip_d;
            tag_q       <= tag_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush && push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign address = address_q;
    assign fetch   = fetch_q;
    assign q_ip    = ip_q;
    assign q_count = count_q;

    // Issue credit accounts for every outstanding read, so a full FIFO can never receive a byte.
    no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && !flush && (count_q == 4'(DEPTH))));

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: queue-level reference model checked every cycle plus directed literal checks.
module tb_prefetch_queue;

    localparam int DEPTH   = 6;
    localparam int ADDR_W  = 20;
    localparam int LATENCY = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              locked;
    logic              bus_hold;
    logic              flush;
    logic [ADDR_W-1:0] flush_addr;
    logic [ADDR_W-1:0] address;
    logic              fetch;
    logic [7:0]        din;
    logic [7:0]        q_data;
    logic [ADDR_W-1:0] q_ip;
    logic              q_valid;
    logic              q_take;
    logic [3:0]        q_count;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clock(clock), .reset(reset), .locked(locked), .bus_hold(bus_hold),
        .flush(flush), .flush_addr(flush_addr), .address(address), .fetch(fetch),
        .din(din), .q_data(q_data), .q_ip(q_ip), .q_valid(q_valid),
        .q_take(q_take), .q_count(q_count)
    );

    always #5 clock = ~clock;

    // Memory contents: default byte is low address byte + 0x10, with per-test overrides.
    logic [7:0] mem_ov [logic [ADDR_W-1:0]];

    function automatic logic [7:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (mem_ov.exists(a)) return mem_ov[a];
        return a[7:0] + 8'h10;
    endfunction

    // Memory port: data for the address presented in one cycle appears on din the next.
    logic              pf = 1'b0;
    logic [ADDR_W-1:0] pa = '0;
    always @(posedge clock) begin
        #1;
        din = pf ? mem_rd(pa) : 8'hEE;
        pf  = fetch;
        pa  = address;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte queue, list of outstanding reads with landing cycle, head ip.
    logic [7:0]        mq[$];
    logic [ADDR_W-1:0] inf_addr[$];
    int                inf_land[$];
    logic [ADDR_W-1:0] m_fptr = '0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [ADDR_W-1:0] m_ip   = '0;
    bit                m_fetch = 1'b0;
    int                cyc = 0;

    function automatic bit m_land();
        return (inf_land.size() > 0) && (inf_land[0] == cyc);
    endfunction

    function automatic bit m_valid();
`ifdef PFQ_BYPASS_EN
        return (mq.size() > 0) || (m_land() && !flush);
`else
        return mq.size() > 0;
`endif
    endfunction

    function automatic logic [7:0] m_head();
        if (mq.size() > 0) return mq[0];
        return mem_rd(inf_addr[0]);
    endfunction

    always @(posedge clock) begin
        bit land, pop, iss, eaten;
        logic [7:0] ld;
        if (reset) begin
            mq.delete(); inf_addr.delete(); inf_land.delete();
            m_fptr = '0; m_addr = '0; m_ip = '0; m_fetch = 1'b0;
        end else begin
            land  = m_land();
            ld    = land ? mem_rd(inf_addr[0]) : 8'h00;
            pop   = q_take && m_valid();
            iss   = locked && !bus_hold && !flush &&
                    (mq.size() + inf_land.size() - (pop ? 1 : 0) < DEPTH);
            eaten = 1'b0;
            if (flush) begin
                mq.delete(); inf_addr.delete(); inf_land.delete();
                m_fptr = flush_addr; m_ip = flush_addr; m_fetch = 1'b0;
            end else begin
                if (land) begin
                    void'(inf_addr.pop_front());
                    void'(inf_land.pop_front());
                end
                if (pop) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    else eaten = 1'b1;
                    m_ip = m_ip + 1'b1;
                end
                if (land && !eaten) mq.push_back(ld);
                if (iss) begin
                    inf_addr.push_back(m_fptr);
                    inf_land.push_back(cyc + LATENCY);
                    m_addr = m_fptr;
                    m_fptr = m_fptr + 1'b1;
                end
                m_fetch = iss;
            end
        end
        cyc++;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("fetch", fetch, m_fetch);
            chk("address", address, m_addr);
            chk("q_valid", q_valid, m_valid());
            chk("q_count", q_count, mq.size());
            if (m_valid()) begin
                chk("q_data", q_data, m_head());
                chk("q_ip", q_ip, m_ip);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int first_k;
        int got;
        int exp_first;
        logic [7:0]        rd_b[$];
        logic [ADDR_W-1:0] rd_ip[$];
        logic [ADDR_W-1:0] prev_ip;
        bit have_prev;

        reset = 1'b1; locked = 1'b1; bus_hold = 1'b0; flush = 1'b0;
        flush_addr = '0; q_take = 1'b0; din = 8'hEE;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_fetch", fetch, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_q_data", q_data, 8'h00);
        chk("rst_q_ip", q_ip, 0);
        chk("rst_address", address, 0);

        // Fill with no consumer: addresses 0..5 then stop.
        reset = 1'b0;
        repeat (12) tick();
        chk("fill_q_count", q_count, 6);
        chk("fill_q_data", q_data, 8'h10);
        chk("fill_q_ip", q_ip, 0);
        chk("fill_fetch", fetch, 0);
        chk("fill_address", address, 5);

        // Consumer takes every cycle: no gaps, bytes 10,11,12...
        q_take = 1'b1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (q_valid) begin
                chk("stream_data", q_data, 8'h10 + 8'(i));
                got++;
            end
            tick();
        end
        chk("stream_nogap", got, 10);

        // Flush with reads in flight.
        mem_ov[20'h00100] = 8'hAA;
        flush = 1'b1; flush_addr = 20'h00100; q_take = 1'b0;
        tick();
        flush = 1'b0;
        first_k = 0;
        for (int k = 1; k <= 8; k++) begin
            if (q_valid && first_k == 0) begin
                first_k = k;
                chk("flush_q_data", q_data, 8'hAA);
                chk("flush_q_ip", q_ip, 20'h00100);
            end
            tick();
        end
`ifdef PFQ_BYPASS_EN
        exp_first = 3;
`else
        exp_first = 4;
`endif
        chk("flush_latency", first_k, exp_first);

        // Address wrap at the top of the linear space.
        mem_ov[20'hFFFFE] = 8'h01; mem_ov[20'hFFFFF] = 8'h02; mem_ov[20'h00000] = 8'h03;
        flush = 1'b1; flush_addr = 20'hFFFFE;
        tick();
        flush = 1'b0; q_take = 1'b1;
        for (int k = 0; k < 20 && rd_b.size() < 3; k++) begin
            if (q_valid && q_take) begin
                rd_b.push_back(q_data);
                rd_ip.push_back(q_ip);
            end
            tick();
        end
        if (rd_b.size() < 3) begin
            chk("wrap_timeout", rd_b.size(), 3);
        end else begin
            chk("wrap_b0", rd_b[0], 8'h01);
            chk("wrap_b1", rd_b[1], 8'h02);
            chk("wrap_b2", rd_b[2], 8'h03);
            chk("wrap_ip2", rd_ip[2], 20'h00000);
        end

        // bus_hold for 3 cycles mid-stream.
        have_prev = 1'b0;
        prev_ip = '0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) bus_hold = 1'b1;
            if (i == 5) bus_hold = 1'b0;
            if (i >= 3 && i <= 5) chk("hold_fetch", fetch, 0);
            if (q_valid && q_take) begin
                chk("hold_data", q_data, mem_rd(q_ip));
                if (have_prev) chk("hold_ip_seq", q_ip, prev_ip + 1'b1);
                prev_ip = q_ip;
                have_prev = 1'b1;
            end
            tick();
        end

        // Reset mid-fetch with four bytes queued and reads outstanding.
        mem_ov.delete();
        q_take = 1'b0; flush = 1'b1; flush_addr = 20'h00200;
        tick();
        flush = 1'b0;
        begin
            int k;
            for (k = 0; k < 20 && q_count != 4'd4; k++) tick();
            if (k == 20) chk("rstmid_timeout", q_count, 4);
        end
        chk("rstmid_inflight", fetch, 1);
        reset = 1'b1;
        tick();
        chk("rstmid_q_valid", q_valid, 0);
        chk("rstmid_q_count", q_count, 0);
        chk("rstmid_fetch", fetch, 0);
        reset = 1'b0; locked = 1'b0;
        repeat (3) begin
            tick();
            chk("rstmid_late", q_count, 0);
            chk("unlocked_fetch", fetch, 0);
        end
        locked = 1'b1;
        repeat (12) tick();
        chk("refill_q_count", q_count, 6);
        chk("refill_q_data", q_data, 8'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
